// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkg
// Purpose  : Shared constants and helpers for the RX frame arbiter:
//            FSM state encoding, counter width and the round-robin pick.
// Revision : 1.0 - initial release
// ============================================================================
package rx_pkg;

   localparam int COUNTER_WIDTH = 32;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_FWD  = 1'b1;

   // Round-robin pick between two candidates; on a tie the port that did not
   // win last time takes the grant.
   function automatic logic rr_pick(input logic [1:0] cand, input logic last_grant);
      logic pick;
      if (cand == 2'b11) begin
         pick = ~last_grant;
      end else begin
         pick = cand[1];
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_port_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rx_port_tracker
// Purpose  : Per-port frame-boundary tracking. Knows whether the port is in
//            the middle of a frame, decides at frame boundaries whether the
//            next frame must be drained (port disabled), sinks drained beats
//            and counts the drained frames.
// Revision : 1.0 - initial release
// ============================================================================
module rx_port_tracker
   import rx_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tvalid_i,
   input  logic                     tlast_i,
   input  logic                     enable_i,
   input  logic                     granted_i,
   input  logic                     accept_i,
   input  logic                     clear_i,
   output logic                     drain_o,
   output logic                     in_frame_o,
   output logic                     tready_o,
   output logic [COUNTER_WIDTH-1:0] drop_count_o
);

   logic                     drain_q;
   logic                     drain_d;
   logic                     in_frame_q;
   logic                     in_frame_d;
   logic [COUNTER_WIDTH-1:0] drop_q;
   logic [COUNTER_WIDTH-1:0] drop_d;

   // Next-state: frame tracking, drain decision at boundaries, drop counting.
   always_comb begin
      in_frame_d = in_frame_q;
      drain_d    = drain_q;
      drop_d     = drop_q;

      // Any accepted beat (forwarded or drained) moves the frame boundary.
      if (accept_i) begin
         in_frame_d = ~tlast_i;
      end

      if (drain_q) begin
         // Once started, a drain always runs to tlast, even if re-enabled.
         if (accept_i && tlast_i) begin
            drain_d = 1'b0;
            drop_d  = drop_q + CNT_ONE;
         end
      end else if (!in_frame_q && !granted_i && tvalid_i && !enable_i) begin
         drain_d = 1'b1;
      end

      // Clear wins over a same-cycle increment.
      if (clear_i) begin
         drop_d = '0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_q    <= 1'b0;
         in_frame_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         drain_q    <= drain_d;
         in_frame_q <= in_frame_d;
         drop_q     <= drop_d;
      end
   end

   assign drain_o      = drain_q;
   assign in_frame_o   = in_frame_q;
   assign tready_o     = drain_q;
   assign drop_count_o = drop_q;

endmodule
`default_nettype wire

// File: rtl/rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_arbiter
// Purpose  : Frame-level round-robin arbiter sharing one RX parsing datapath
//            between two MAC AXI-Stream ports. A port holds the grant from
//            its first beat through tlast; disabled ports are drained.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_arbiter
   import rx_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               port_enable,

   input  logic [DATA_WIDTH-1:0]    s0_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s0_axis_tkeep,
   input  logic                     s0_axis_tvalid,
   input  logic                     s0_axis_tlast,
   output logic                     s0_axis_tready,

   input  logic [DATA_WIDTH-1:0]    s1_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s1_axis_tkeep,
   input  logic                     s1_axis_tvalid,
   input  logic                     s1_axis_tlast,
   output logic                     s1_axis_tready,

   output logic [DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tid,

   output logic [COUNTER_WIDTH-1:0] frame_count0,
   output logic [COUNTER_WIDTH-1:0] frame_count1,
   output logic [COUNTER_WIDTH-1:0] drop_count0,
   output logic [COUNTER_WIDTH-1:0] drop_count1,
   input  logic                     clear_counters
);

   logic [0:0]               state_q;
   logic [0:0]               state_d;
   logic                     grant_q;
   logic                     grant_d;
   logic                     last_grant_q;
   logic                     last_grant_d;
   logic [COUNTER_WIDTH-1:0] frame_count0_q;
   logic [COUNTER_WIDTH-1:0] frame_count0_d;
   logic [COUNTER_WIDTH-1:0] frame_count1_q;
   logic [COUNTER_WIDTH-1:0] frame_count1_d;

   logic [DATA_WIDTH-1:0]    sdata [2];
   logic [KEEP_WIDTH-1:0]    skeep [2];
   logic [1:0]               svalid;
   logic [1:0]               slast;
   logic [1:0]               sready;
   logic [1:0]               granted;
   logic [1:0]               accept;
   logic [1:0]               drain;
   logic [1:0]               in_frame;
   logic [1:0]               drain_ready;
   logic [1:0]               cand;
   logic [COUNTER_WIDTH-1:0] drop_count [2];
   logic                     fwd;
   logic                     m_hs_last;

   assign sdata[0]  = s0_axis_tdata;
   assign sdata[1]  = s1_axis_tdata;
   assign skeep[0]  = s0_axis_tkeep;
   assign skeep[1]  = s1_axis_tkeep;
   assign svalid    = {s1_axis_tvalid, s0_axis_tvalid};
   assign slast     = {s1_axis_tlast,  s0_axis_tlast};

   assign fwd       = (state_q == ST_FWD);

   // Output mux: the granted port drives the decapsulator while forwarding.
   assign m_axis_tdata  = sdata[grant_q];
   assign m_axis_tkeep  = skeep[grant_q];
   assign m_axis_tvalid = fwd & svalid[grant_q];
   assign m_axis_tlast  = fwd & slast[grant_q];
   assign m_axis_tid    = grant_q;

   assign m_hs_last     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   assign s0_axis_tready = sready[0];
   assign s1_axis_tready = sready[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign granted[gi] = fwd & (grant_q == 1'(gi));
         assign sready[gi]  = drain_ready[gi] | (granted[gi] & m_axis_tready);
         assign accept[gi]  = svalid[gi] & sready[gi];
         assign cand[gi]    = svalid[gi] & port_enable[gi] & ~drain[gi] & ~in_frame[gi];

         rx_port_tracker u_tracker (
            .clk          (clk),
            .rst          (rst),
            .tvalid_i     (svalid[gi]),
            .tlast_i      (slast[gi]),
            .enable_i     (port_enable[gi]),
            .granted_i    (granted[gi]),
            .accept_i     (accept[gi]),
            .clear_i      (clear_counters),
            .drain_o      (drain[gi]),
            .in_frame_o   (in_frame[gi]),
            .tready_o     (drain_ready[gi]),
            .drop_count_o (drop_count[gi])
         );
      end
   endgenerate

   // Arbitration FSM: pick a port in IDLE, hold it until its tlast transfers.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (|cand) begin
               grant_d      = rr_pick(cand, last_grant_q);
               last_grant_d = grant_d;
               state_d      = ST_FWD;
            end
         end
         ST_FWD: begin
            if (m_hs_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Forwarded-frame counters; clear wins over a same-cycle increment.
   always_comb begin
      frame_count0_d = frame_count0_q;
      frame_count1_d = frame_count1_q;
      if (m_hs_last && !grant_q) begin
         frame_count0_d = frame_count0_q + CNT_ONE;
      end
      if (m_hs_last && grant_q) begin
         frame_count1_d = frame_count1_q + CNT_ONE;
      end
      if (clear_counters) begin
         frame_count0_d = '0;
         frame_count1_d = '0;
      end
   end

   // State registers; last_grant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         grant_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         frame_count0_q <= '0;
         frame_count1_q <= '0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_grant_q   <= last_grant_d;
         frame_count0_q <= frame_count0_d;
         frame_count1_q <= frame_count1_d;
      end
   end

   assign frame_count0 = frame_count0_q;
   assign frame_count1 = frame_count1_q;
   assign drop_count0  = drop_count[0];
   assign drop_count1  = drop_count[1];

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_arbiter
// Purpose  : Directed self-checking bench for rx_frame_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_arbiter
   import rx_pkg::*;
;

   logic        clk;
   logic        rst;
   logic [1:0]  port_enable;
   logic [63:0] s0_axis_tdata;
   logic [7:0]  s0_axis_tkeep;
   logic        s0_axis_tvalid;
   logic        s0_axis_tlast;
   logic        s0_axis_tready;
   logic [63:0] s1_axis_tdata;
   logic [7:0]  s1_axis_tkeep;
   logic        s1_axis_tvalid;
   logic        s1_axis_tlast;
   logic        s1_axis_tready;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        m_axis_tid;
   logic [31:0] frame_count0;
   logic [31:0] frame_count1;
   logic [31:0] drop_count0;
   logic [31:0] drop_count1;
   logic        clear_counters;

   int          n_cmp;
   int          n_err;
   logic [73:0] cap_q[$];

   rx_frame_arbiter #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .port_enable    (port_enable),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tkeep  (s0_axis_tkeep),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tlast  (s0_axis_tlast),
      .s0_axis_tready (s0_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tkeep  (s1_axis_tkeep),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tlast  (s1_axis_tlast),
      .s1_axis_tready (s1_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tkeep   (m_axis_tkeep),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tid     (m_axis_tid),
      .frame_count0   (frame_count0),
      .frame_count1   (frame_count1),
      .drop_count0    (drop_count0),
      .drop_count1    (drop_count1),
      .clear_counters (clear_counters)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every beat that will transfer at the coming rising edge.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         cap_q.push_back({m_axis_tid, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic drive_beat(input int port, input logic v, input logic [63:0] d,
                             input logic [7:0] k, input logic l);
      if (port == 0) begin
         s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tkeep = k; s0_axis_tlast = l;
      end else begin
         s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tkeep = k; s1_axis_tlast = l;
      end
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic send_frame(input int port, input int nbeats, input logic [63:0] base);
      logic rdy;
      logic done;
      int   guard;
      for (int b = 0; b < nbeats; b++) begin
         drive_beat(port, 1'b1, base + 64'(b), (b == nbeats - 1) ? 8'h0F : 8'hFF,
                    b == nbeats - 1);
         done  = 1'b0;
         guard = 0;
         while (!done) begin
            @(negedge clk);
            rdy = (port == 0) ? s0_axis_tready : s1_axis_tready;
            @(posedge clk); #1;
            if (rdy) begin
               done = 1'b1;
            end else begin
               guard++;
               if (guard > 200) begin
                  n_cmp++; n_err++;
                  $display("FAIL send_timeout port=%0d beat=%0d: tready=0, required 1", port, b);
                  drive_beat(port, 1'b0, 64'd0, 8'd0, 1'b0);
                  return;
               end
            end
         end
      end
      drive_beat(port, 1'b0, 64'd0, 8'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      port_enable    = 2'b11;
      m_axis_tready  = 1'b1;
      clear_counters = 1'b0;
      drive_beat(0, 1'b0, 64'd0, 8'd0, 1'b0);
      drive_beat(1, 1'b0, 64'd0, 8'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cap_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (s0_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_s0_ready got=%b exp=0", s0_axis_tready); end
      n_cmp++; if (s1_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_s1_ready got=%b exp=0", s1_axis_tready); end
      n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_axis_tvalid); end
      n_cmp++; if (m_axis_tid !== 1'b0) begin n_err++; $display("FAIL rst_m_tid got=%b exp=0", m_axis_tid); end
      n_cmp++; if ({frame_count0, frame_count1, drop_count0, drop_count1} !== 128'd0) begin
         n_err++; $display("FAIL rst_counters got=%h/%h/%h/%h exp=0", frame_count0, frame_count1, drop_count0, drop_count1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      logic [73:0] exp;
      do_reset();
      fork
         send_frame(0, 4, 64'h100);
         begin
            @(negedge clk);
            n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_arb_cycle m_valid got=%b exp=0", m_axis_tvalid); end
            @(negedge clk);
            n_cmp++; if ({m_axis_tvalid, m_axis_tid} !== 2'b10) begin n_err++; $display("FAIL single_first_beat valid,tid got=%b exp=10", {m_axis_tvalid, m_axis_tid}); end
         end
      join
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (cap_q.size() != 4) begin n_err++; $display("FAIL single_beats got=%0d exp=4", cap_q.size()); end
      for (int b = 0; b < 4; b++) begin
         exp = {1'b0, b == 3, (b == 3) ? 8'h0F : 8'hFF, 64'h100 + 64'(b)};
         n_cmp++;
         if (b >= cap_q.size() || cap_q[b] !== exp) begin
            n_err++; $display("FAIL single_beat%0d got=%h exp=%h", b, (b < cap_q.size()) ? cap_q[b] : 74'bx, exp);
         end
      end
      n_cmp++; if (frame_count0 !== 32'd1) begin n_err++; $display("FAIL single_fc0 got=%0d exp=1", frame_count0); end
      @(posedge clk); #1;
   endtask

   task automatic test_tie();
      logic [73:0] exp;
      int          k;
      do_reset();
      fork
         for (int f = 0; f < 3; f++) send_frame(0, 2, 64'h2000 + 64'(f * 16));
         for (int f = 0; f < 3; f++) send_frame(1, 2, 64'h3000 + 64'(f * 16));
      join
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (cap_q.size() != 12) begin n_err++; $display("FAIL tie_beats got=%0d exp=12", cap_q.size()); end
      for (int i = 0; i < 12; i++) begin
         k   = i / 2;
         exp = {1'(k % 2), (i % 2) == 1, (i % 2 == 1) ? 8'h0F : 8'hFF,
                ((k % 2 == 0) ? 64'h2000 : 64'h3000) + 64'((k / 2) * 16 + (i % 2))};
         n_cmp++;
         if (i >= cap_q.size() || cap_q[i] !== exp) begin
            n_err++; $display("FAIL tie_beat%0d got=%h exp=%h", i, (i < cap_q.size()) ? cap_q[i] : 74'bx, exp);
         end
      end
      n_cmp++; if (frame_count0 !== 32'd3) begin n_err++; $display("FAIL tie_fc0 got=%0d exp=3", frame_count0); end
      n_cmp++; if (frame_count1 !== 32'd3) begin n_err++; $display("FAIL tie_fc1 got=%0d exp=3", frame_count1); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [73:0] exp;
      logic        bp_done;
      do_reset();
      bp_done = 1'b0;
      fork
         begin
            send_frame(1, 8, 64'h5100);
            bp_done = 1'b1;
         end
         begin
            while (!bp_done) begin
               @(posedge clk); #1;
               m_axis_tready = ~m_axis_tready;
            end
            m_axis_tready = 1'b1;
         end
         begin
            while (!bp_done) begin
               @(negedge clk);
               if (m_axis_tvalid) begin
                  n_cmp++;
                  if (s1_axis_tready !== m_axis_tready) begin
                     n_err++; $display("FAIL bp_s1_ready got=%b exp=%b", s1_axis_tready, m_axis_tready);
                  end
               end
            end
         end
      join
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (cap_q.size() != 8) begin n_err++; $display("FAIL bp_beats got=%0d exp=8", cap_q.size()); end
      for (int b = 0; b < 8; b++) begin
         exp = {1'b1, b == 7, (b == 7) ? 8'h0F : 8'hFF, 64'h5100 + 64'(b)};
         n_cmp++;
         if (b >= cap_q.size() || cap_q[b] !== exp) begin
            n_err++; $display("FAIL bp_beat%0d got=%h exp=%h", b, (b < cap_q.size()) ? cap_q[b] : 74'bx, exp);
         end
      end
      n_cmp++; if (frame_count1 !== 32'd1) begin n_err++; $display("FAIL bp_fc1 got=%0d exp=1", frame_count1); end
      @(posedge clk); #1;
   endtask

   task automatic test_disabled();
      logic [73:0] exp;
      int          rdy_cycles;
      do_reset();
      port_enable = 2'b10;
      rdy_cycles  = 0;
      fork
         send_frame(0, 5, 64'h400);
         send_frame(1, 3, 64'h500);
         begin
            repeat (20) begin
               @(negedge clk);
               if (s0_axis_tready) rdy_cycles++;
               n_cmp++;
               if (m_axis_tvalid && m_axis_tid == 1'b0) begin
                  n_err++; $display("FAIL dis_leak m_valid with tid got=0 exp=1");
               end
            end
         end
      join
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (rdy_cycles != 5) begin n_err++; $display("FAIL dis_s0_ready_cycles got=%0d exp=5", rdy_cycles); end
      n_cmp++; if (drop_count0 !== 32'd1) begin n_err++; $display("FAIL dis_drop0 got=%0d exp=1", drop_count0); end
      n_cmp++; if (frame_count0 !== 32'd0) begin n_err++; $display("FAIL dis_fc0 got=%0d exp=0", frame_count0); end
      n_cmp++; if (frame_count1 !== 32'd1) begin n_err++; $display("FAIL dis_fc1 got=%0d exp=1", frame_count1); end
      n_cmp++; if (cap_q.size() != 3) begin n_err++; $display("FAIL dis_beats got=%0d exp=3", cap_q.size()); end
      for (int b = 0; b < 3; b++) begin
         exp = {1'b1, b == 2, (b == 2) ? 8'h0F : 8'hFF, 64'h500 + 64'(b)};
         n_cmp++;
         if (b >= cap_q.size() || cap_q[b] !== exp) begin
            n_err++; $display("FAIL dis_beat%0d got=%h exp=%h", b, (b < cap_q.size()) ? cap_q[b] : 74'bx, exp);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mid_disable();
      logic [73:0] exp;
      int          guard;
      do_reset();
      fork
         send_frame(0, 6, 64'h600);
         begin
            guard = 0;
            while (cap_q.size() < 2 && guard < 50) begin
               @(negedge clk);
               guard++;
            end
            @(posedge clk); #1;
            port_enable = 2'b10;
         end
      join
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (cap_q.size() != 6) begin n_err++; $display("FAIL mid_beats got=%0d exp=6", cap_q.size()); end
      for (int b = 0; b < 6; b++) begin
         exp = {1'b0, b == 5, (b == 5) ? 8'h0F : 8'hFF, 64'h600 + 64'(b)};
         n_cmp++;
         if (b >= cap_q.size() || cap_q[b] !== exp) begin
            n_err++; $display("FAIL mid_beat%0d got=%h exp=%h", b, (b < cap_q.size()) ? cap_q[b] : 74'bx, exp);
         end
      end
      n_cmp++; if (frame_count0 !== 32'd1) begin n_err++; $display("FAIL mid_fc0 got=%0d exp=1", frame_count0); end
      @(posedge clk); #1;
      send_frame(0, 3, 64'h700);
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (drop_count0 !== 32'd1) begin n_err++; $display("FAIL mid_next_drop0 got=%0d exp=1", drop_count0); end
      n_cmp++; if (cap_q.size() != 6) begin n_err++; $display("FAIL mid_next_beats got=%0d exp=6", cap_q.size()); end
      n_cmp++; if (frame_count0 !== 32'd1) begin n_err++; $display("FAIL mid_next_fc0 got=%0d exp=1", frame_count0); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_clear();
      // Reset in the middle of a frame.
      do_reset();
      drive_beat(0, 1'b1, 64'hABC, 8'hFF, 1'b0);
      repeat (4) @(negedge clk);
      n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rc_beat3_valid got=%b exp=1", m_axis_tvalid); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({m_axis_tvalid, s0_axis_tready, m_axis_tid} !== 3'b000) begin
         n_err++; $display("FAIL rc_async_outputs valid,ready,tid got=%b exp=000", {m_axis_tvalid, s0_axis_tready, m_axis_tid});
      end
      n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rc_state got=%b exp=%b", dut.state_q, ST_IDLE); end
      drive_beat(0, 1'b0, 64'd0, 8'd0, 1'b0);

      // Clear in the same cycle as a final beat.
      do_reset();
      send_frame(0, 1, 64'h800);
      drive_beat(0, 1'b1, 64'h810, 8'hFF, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b10) begin n_err++; $display("FAIL rc_clr_beat0 valid,last got=%b exp=10", {m_axis_tvalid, m_axis_tlast}); end
      n_cmp++; if (frame_count0 !== 32'd1) begin n_err++; $display("FAIL rc_clr_pre_fc0 got=%0d exp=1", frame_count0); end
      @(posedge clk); #1;
      drive_beat(0, 1'b1, 64'h811, 8'h0F, 1'b1);
      clear_counters = 1'b1;
      @(negedge clk);
      n_cmp++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b11) begin n_err++; $display("FAIL rc_clr_beat1 valid,last got=%b exp=11", {m_axis_tvalid, m_axis_tlast}); end
      @(posedge clk); #1;
      drive_beat(0, 1'b0, 64'd0, 8'd0, 1'b0);
      clear_counters = 1'b0;
      @(negedge clk);
      n_cmp++; if (frame_count0 !== 32'd0) begin n_err++; $display("FAIL rc_clr_fc0 got=%0d exp=0", frame_count0); end

      // Wrap from all-ones, using a 1-beat frame.
      @(negedge clk);
      force dut.frame_count1_q = 32'hFFFF_FFFF;
      #1 release dut.frame_count1_q;
      n_cmp++; if (frame_count1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rc_preload_fc1 got=%h exp=ffffffff", frame_count1); end
      @(posedge clk); #1;
      cap_q.delete();
      send_frame(1, 1, 64'h900);
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (frame_count1 !== 32'd0) begin n_err++; $display("FAIL rc_wrap_fc1 got=%h exp=0", frame_count1); end
      n_cmp++;
      if (cap_q.size() != 1 || cap_q[0] !== {1'b1, 1'b1, 8'h0F, 64'h900}) begin
         n_err++; $display("FAIL rc_one_beat got=%h (n=%0d) exp=%h", (cap_q.size() > 0) ? cap_q[0] : 74'bx, cap_q.size(), {1'b1, 1'b1, 8'h0F, 64'h900});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_disabled();
      test_mid_disable();
      test_reset_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rx_frame_arbiter.md
# rx_frame_arbiter

Frame-level round-robin arbiter that shares the single RX Ethernet header-parsing datapath between two MAC RX AXI-Stream ports. It sits between the two MAC receive interfaces and the decapsulator's `s_axis` input. It grants the datapath to one port for a whole frame, from the first beat through `tlast`. Frames from disabled ports are silently drained and counted.

## Interface
- `DATA_WIDTH`, 64: stream data width in bits.
- `KEEP_WIDTH`, DATA_WIDTH/8: tkeep width.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `port_enable` in 2: per-port enable, bit i = port i.
- `s0_axis_tdata/tkeep/tvalid/tlast` in DATA_WIDTH/KEEP_WIDTH/1/1: port 0 input stream.
- `s0_axis_tready` out 1: port 0 ready.
- `s1_axis_*`: same as port 0, for port 1.
- `m_axis_tdata/tkeep/tvalid/tlast` out DATA_WIDTH/KEEP_WIDTH/1/1: stream to the decapsulator.
- `m_axis_tready` in 1: decapsulator ready.
- `m_axis_tid` out 1: source port of the current beat.
- `frame_count0`, `frame_count1` out 32 each: frames forwarded per port.
- `drop_count0`, `drop_count1` out 32 each: frames drained per port.
- `clear_counters` in 1: synchronous clear of all four counters.

## Operation
- FSM states: IDLE, FWD.
- IDLE
  - Candidate i = `si_tvalid & port_enable[i] & ~drain[i] & ~in_frame[i]`.
  - One candidate: grant it.
  - Two candidates: grant the port ≠ `last_grant`.
  - On grant: register `grant`, set `last_grant` = grant, go to FWD.
  - No candidate: stay in IDLE.
- FWD
  - Granted port's data, keep, valid and last are muxed combinationally to `m_axis`. `m_axis_tid` = grant.
  - `sG_tready` = `m_axis_tready`.
  - On an `m_axis` handshake with tlast: increment `frame_countG` and return to IDLE.
  - Disabling the granted port mid-frame has no effect; the frame completes.
- Per-port frame tracking
  - `in_frame[i]` sets on any accepted non-last beat of port i and clears on an accepted last beat.
  - `drain[i]` is evaluated only at a frame boundary (`in_frame[i]`=0, port not granted). It sets when `si_tvalid & ~port_enable[i]`.
  - While `drain[i]`: `si_tready`=1 and beats are discarded. On the accepted tlast, increment `drop_count[i]` and clear `drain[i]`.
  - Re-enabling the port mid-drain does not abort the drain.
- Ungranted, non-draining ports: tready=0.
- Counters
  - All four are 32-bit and wrap modulo 2^32.
  - `clear_counters` takes priority over a same-cycle increment.
- Reset values
  - All `si_tready`=0, `m_axis_tvalid`=0, `m_axis_tid`=0, all counters 0.
  - State IDLE, `last_grant`=1 (port 0 wins the first tie), `drain`=0, `in_frame`=0.
- Reset asserted mid-frame: the partial frame is abandoned immediately and `m_axis_tvalid` drops asynchronously. Downstream must tolerate the truncated frame.

## Timing
- Arbitration costs one cycle: a frame presented in IDLE is visible on `m_axis` the cycle after the grant registers.
- Beats after the first pass through combinationally, with zero latency and full throughput.
- Back-to-back frames lose one cycle per frame (the IDLE bubble).
- `m_axis_tvalid` in IDLE is 0. `m_axis_tdata`/`tkeep` are don't-care whenever valid=0.
- Drain runs concurrently with forwarding on the other port; there is no interaction.
- A 1-beat frame (tvalid & tlast on the first beat) is handled like any other: one arbitration cycle, then one transfer.
- Fairness: with both ports continuously valid and enabled, grants strictly alternate 0,1,0,1.

## Structure
- Shared package `rx_pkg`: FSM state encoding (IDLE=0, FWD=1) and the `COUNTER_WIDTH`=32 constant.
- One natural sub-module: `rx_port_tracker`, instantiated twice. It owns `in_frame`, `drain` and the drop counter, and outputs `drain` and its tready contribution.
- Top level holds the FSM, the round-robin register, the output mux and the frame counters.

## Test plan
- Single port: port 0 sends a 4-beat frame, port 1 idle, `m_axis_tready`=1.
  - `m_axis` beats start 1 cycle after the grant with `m_axis_tid`=0.
  - `frame_count0`=1.
- Tie: both ports valid at the same time, each sending three 2-beat frames.
  - Output order is tid 0,1,0,1,0,1.
  - Both frame counters = 3.
  - There are no interleaved beats within a frame.
- Backpressure: port 1 sends an 8-beat frame while `m_axis_tready` toggles 1,0,1,0.
  - All 8 beats arrive in order, tdata unchanged.
  - `s1_axis_tready` mirrors `m_axis_tready`.
- Disabled port: `port_enable`=2'b10, port 0 sends a 5-beat frame.
  - `s0_axis_tready`=1 for 5 cycles, `m_axis_tvalid` stays 0.
  - `drop_count0`=1.
  - Port 1 frames are forwarded concurrently.
- Mid-frame disable: clear `port_enable[0]` at beat 2 of a 6-beat frame.
  - All 6 beats are forwarded and `frame_count0` increments.
  - The next port 0 frame is drained.
- Reset and clear:
  - Assert `rst` at beat 3 of a frame: outputs are 0 immediately and the state is IDLE.
  - `clear_counters` pulsed in the same cycle as a final beat leaves that counter = 0.
  - A counter preloaded to 0xFFFFFFFF wraps to 0 on the next increment.
